// File: rtl/gpio_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// gpio_cmd_sequencer
//
// Hardware initiator for the accelerator GPIO command protocol. It turns simple
// valid/ready command handshakes into correctly timed 32-bit word sequences on
// the host-to-fabric GPIO word. It also samples the fabric-to-host word for
// read-back.
//
// Word format on o_gpio:
//   [3:0]              opcode (0x0 idle, 0x5 reset/size, 0xA SOP arm, 0x2 run)
//   [4]                strobe
//   [7:5]              kernel select {1'b1, sel}, 000 = none
//   [RAM_WIDTH+7:8]    payload
//   upper bits         always 0
//
// Ports:
//   CLK100MHZ    system clock
//   i_reset      asynchronous, active-high reset
//   i_cmd_valid  command or kernel beat offered
//   o_cmd_ready  command or beat accepted this cycle (IDLE / KWAIT only)
//   i_cmd_op     0 RESET, 1 LOAD_KERNEL, 2 SOP, 3 READ
//   i_cmd_sel    kernel memory 1..3 for LOAD_KERNEL (0 treated as 1)
//   i_cmd_data   image size (RESET) or coefficient (kernel beat)
//   i_cmd_last   marks the final kernel beat
//   o_gpio       registered word to the accelerator
//   i_gpio       word from the accelerator
//   o_rd_data    captured read-back word
//   o_rd_valid   one-cycle pulse when o_rd_data updates
//   o_busy       high in every state except IDLE and KWAIT
// -----------------------------------------------------------------------------
module gpio_cmd_sequencer #(
   parameter int GPIO_D    = 32,
   parameter int RAM_WIDTH = 13,
   parameter int HOLD_CYC  = 2,
   parameter int NB_HOLD   = 8
) (
   input  logic                 CLK100MHZ,
   input  logic                 i_reset,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic [1:0]           i_cmd_op,
   input  logic [1:0]           i_cmd_sel,
   input  logic [RAM_WIDTH-1:0] i_cmd_data,
   input  logic                 i_cmd_last,
   output logic [GPIO_D-1:0]    o_gpio,
   input  logic [GPIO_D-1:0]    i_gpio,
   output logic [GPIO_D-1:0]    o_rd_data,
   output logic                 o_rd_valid,
   output logic                 o_busy
);

   // A hold of 0 cycles is meaningless on a registered output; treat it as 1.
   localparam int                 HOLD_EFF  = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
   localparam logic [NB_HOLD-1:0] HOLD_LAST = NB_HOLD'(HOLD_EFF - 1);

   localparam logic [3:0] OP_IDLE    = 4'h0;
   localparam logic [3:0] OP_RST     = 4'h5;
   localparam logic [3:0] OP_SOP_ARM = 4'hA;
   localparam logic [3:0] OP_RUN     = 4'h2;

   typedef enum logic [3:0] {
      S_IDLE, S_RST_A, S_RST_B, S_RST_C, S_KSEL, S_KHI, S_KLO,
      S_KWAIT, S_SOP_A, S_RD_HI, S_RD_LO
   } state_t;

   state_t                 state_q, state_d;
   logic [NB_HOLD-1:0]     hold_q, hold_d;
   logic [RAM_WIDTH-1:0]   data_q, data_d;
   logic [1:0]             sel_q, sel_d;
   logic                   last_q, last_d;
   logic                   tail_q, tail_d;     // KLO of last beat is emitting its 0x0 tail
   logic                   live_q;             // first clock after reset release has passed
   logic [GPIO_D-1:0]      gpio_q, gpio_d;
   logic [GPIO_D-1:0]      rd_data_q, rd_data_d;
   logic                   rd_valid_q, rd_valid_d;

   logic                   cmd_ready;
   logic                   accept;
   logic                   hold_done;

   // Builds a full GPIO word from payload and the low control byte.
   function automatic logic [GPIO_D-1:0] pack_word(input logic [RAM_WIDTH-1:0] payload,
                                                   input logic [7:0]           low);
      logic [GPIO_D-1:0] w;
      w                  = '0;
      w[RAM_WIDTH+7:8]   = payload;
      w[7:0]             = low;
      return w;
   endfunction

   // Ready is held low until one clock after reset release.
   assign cmd_ready = live_q & ((state_q == S_IDLE) | (state_q == S_KWAIT));
   assign accept    = i_cmd_valid & cmd_ready;
   assign hold_done = (hold_q == HOLD_LAST);

   // ---------------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK100MHZ or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         hold_q     <= '0;
         data_q     <= '0;
         sel_q      <= '0;
         last_q     <= 1'b0;
         tail_q     <= 1'b0;
         live_q     <= 1'b0;
         gpio_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         data_q     <= data_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         tail_q     <= tail_d;
         live_q     <= 1'b1;
         gpio_q     <= gpio_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // ---------------------------------------------------------------- next state
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      data_d  = data_q;
      sel_d   = sel_q;
      last_d  = last_q;
      tail_d  = tail_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               data_d = i_cmd_data;
               hold_d = '0;
               tail_d = 1'b0;
               case (i_cmd_op)
                  2'd0:    state_d = S_RST_A;
                  2'd1: begin
                     sel_d   = (i_cmd_sel == 2'd0) ? 2'd1 : i_cmd_sel;
                     last_d  = i_cmd_last;
                     state_d = S_KSEL;
                  end
                  2'd2:    state_d = S_SOP_A;
                  default: state_d = S_RD_HI;
               endcase
            end
         end

         // Only payload and last are taken here; op and sel belong to the load.
         // The beat handshake can only happen in this state, so it lasts at
         // least one cycle between beats.
         S_KWAIT: begin
            if (accept) begin
               data_d  = i_cmd_data;
               last_d  = i_cmd_last;
               hold_d  = '0;
               state_d = S_KHI;
            end
         end

         default: begin
            if (!hold_done) begin
               hold_d = hold_q + NB_HOLD'(1);
            end else begin
               hold_d = '0;
               case (state_q)
                  S_RST_A: state_d = S_RST_B;
                  S_RST_B: state_d = S_RST_C;
                  S_KSEL:  state_d = S_KHI;
                  S_KHI:   state_d = S_KLO;
                  S_KLO: begin
                     if (!last_q)      state_d = S_KWAIT;
                     else if (!tail_q) tail_d  = 1'b1;   // stay one more hold for the 0x0 word
                     else begin
                        tail_d  = 1'b0;
                        state_d = S_IDLE;
                     end
                  end
                  S_RD_HI: state_d = S_RD_LO;
                  default: state_d = S_IDLE;             // RST_C, SOP_A, RD_LO
               endcase
            end
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // The word for the state being entered is computed here and registered, so
   // it appears on o_gpio in the first cycle of that state.
   always_comb begin
      gpio_d     = gpio_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      case (state_d)
         S_RST_A: gpio_d = pack_word('0, {4'h0, OP_RST});
         S_RST_B: gpio_d = pack_word(data_d, {4'h0, OP_RST});
         S_RST_C: gpio_d = '0;
         S_KSEL:  gpio_d = pack_word('0, {1'b1, sel_d, 1'b0, OP_IDLE});
         S_KHI:   gpio_d = pack_word(data_d, {1'b1, sel_d, 1'b1, OP_IDLE});
         S_KLO:   gpio_d = tail_d ? '0 : pack_word(data_d, {1'b1, sel_d, 1'b0, OP_IDLE});
         S_SOP_A: gpio_d = pack_word('0, {4'h0, OP_SOP_ARM});
         S_RD_HI: gpio_d = pack_word('0, {3'b000, 1'b1, OP_IDLE});
         S_RD_LO: gpio_d = '0;
         S_IDLE: begin
            // Leaving SOP arms the run word, which then stays until the next command.
            if (state_q == S_SOP_A) gpio_d = pack_word('0, {4'h0, OP_RUN});
         end
         default: ;                                      // KWAIT keeps the KLO word
      endcase

      if ((state_q == S_RD_LO) && hold_done) begin
         rd_data_d  = i_gpio;
         rd_valid_d = 1'b1;
      end
   end

   assign o_cmd_ready = cmd_ready;
   assign o_gpio      = gpio_q;
   assign o_rd_data   = rd_data_q;
   assign o_rd_valid  = rd_valid_q;
   assign o_busy      = (state_q != S_IDLE) && (state_q != S_KWAIT);

endmodule

// File: doc/gpio_cmd_sequencer.md
# gpio_cmd_sequencer

Hardware initiator for the accelerator's GPIO command protocol. It drives the 32-bit host-to-fabric word (the accelerator's `gpio_o_data_tri_o`) and samples the fabric-to-host word (`gpio_i_data_tri_i`). It converts simple command handshakes into correctly timed word sequences: reset/size latch, kernel-memory load with strobe toggling, start-of-processing, and strobed result read-back. It replaces hand-written stimulus and MicroBlaze drivers, so the convolution pipeline can be exercised on-chip without a CPU.

## Interface
- GPIO_D, 32, width of the GPIO words
- RAM_WIDTH, 13, payload width, carried in word bits [RAM_WIDTH+7:8]
- HOLD_CYC, 2, clock cycles each emitted word is held; 0 behaves as 1
- NB_HOLD, 8, width of the hold counter

- CLK100MHZ  in  1  single system clock
- i_reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command or kernel beat offered
- o_cmd_ready  out  1  sequencer accepts command or beat this cycle
- i_cmd_op  in  2  command: 0 RESET, 1 LOAD_KERNEL, 2 SOP, 3 READ
- i_cmd_sel  in  2  kernel memory for LOAD_KERNEL: 1, 2, 3; 0 is treated as 1
- i_cmd_data  in  RAM_WIDTH  payload: image size for RESET, coefficient for kernel beats
- i_cmd_last  in  1  marks the final kernel beat
- o_gpio  out  GPIO_D  word to the accelerator, registered
- i_gpio  in  GPIO_D  word from the accelerator
- o_rd_data  out  GPIO_D  captured read-back word
- o_rd_valid  out  1  one-cycle pulse when o_rd_data updates
- o_busy  out  1  high in any state other than IDLE and KWAIT

## Operation
- Word format:
  - [3:0] opcode: 0x0 idle, 0x5 reset/size, 0xA SOP arm, 0x2 run.
  - [4] strobe.
  - [7:5] kernel select: 3'b1,sel; 000 means none.
  - [RAM_WIDTH+7:8] payload.
  - Upper bits are always 0.
- States: IDLE, RST_A, RST_B, RST_C, KSEL, KHI, KLO, KWAIT, SOP_A, RD_HI, RD_LO.
- Each emitting state holds o_gpio for HOLD_CYC cycles, counted by the hold counter. The transition happens on the last hold cycle.
- RESET (data D): RST_A emits 0x5. RST_B emits {D,8'h05}. RST_C emits 0x0. Then IDLE.
- LOAD_KERNEL (sel S, first beat in the same handshake):
  - KSEL emits {3'b1,S,5'h0}.
  - For each beat, KHI emits payload with strobe=1, then KLO emits the same payload with strobe=0.
  - After KLO of a non-last beat, go to KWAIT. KWAIT holds the KLO word with ready=1; op and sel are ignored there, and each accepted beat goes to KHI.
  - After KLO of the last beat, emit 0x0 for HOLD_CYC cycles (in KLO's tail), then IDLE.
- SOP: SOP_A emits 0x0A, then IDLE with o_gpio=0x02, held until the next command.
- READ:
  - RD_HI emits 0x10; RD_LO emits 0x00.
  - On the last cycle of RD_LO, i_gpio is registered into o_rd_data and o_rd_valid pulses on the following cycle.
- In IDLE, o_gpio holds the last emitted word.
- o_cmd_ready=1 only in IDLE and KWAIT, and never while i_reset is high.

## Timing
- Reset values: o_gpio=0, o_rd_data=0, o_rd_valid=0, o_busy=0, o_cmd_ready=0 (goes to 1 on the first clock after deassertion). State is IDLE and the hold counter is 0.
- Handshake: transfer on a rising edge with valid&ready. The first word of the sequence appears on o_gpio on the next cycle.
- Command latencies from the handshake edge to IDLE:
  - RESET: 3·HOLD_CYC cycles.
  - SOP: HOLD_CYC cycles.
  - READ: 2·HOLD_CYC cycles.
  - LOAD_KERNEL: (1 + 2·beats + 1)·HOLD_CYC cycles, plus KWAIT stall time.
- o_rd_valid is asserted 2·HOLD_CYC+1 cycles after the READ handshake.
- i_cmd_valid with ready=0 is ignored; no queuing. The offering side must hold valid.
- KWAIT starvation: stay indefinitely with o_gpio unchanged.
- Async reset mid-sequence: all outputs take their reset values immediately and the sequence is abandoned. A new command is accepted after deassertion.
- Strobe edges are spaced at least HOLD_CYC cycles apart. i_cmd_data is latched at the handshake, so later changes do not affect the emitted word.

## Test plan
- RESET, data=0x1B7, HOLD_CYC=2 -> o_gpio = 0x00005 ×2, then 0x1B705 ×2, then 0x00000 ×2. o_cmd_ready returns 1 on cycle 7.
- LOAD_KERNEL sel=1, beats 0x7F, 0x7F, 0x7E(last) -> o_gpio = 0xA0 ×2, 0x7FB0 ×2, 0x7FA0 ×2, 0x7FB0 ×2, 0x7FA0 ×2, 0x7EB0 ×2, 0x7EA0 ×2, 0x0 ×2. Repeat with sel=2 and sel=3: select words are 0xC0/0xD0 and 0xE0/0xF0.
- SOP -> o_gpio = 0x0A ×2, then 0x02 held for 50 cycles while idle.
- READ with i_gpio=0x0000DEAD -> o_gpio = 0x10 ×2 then 0x00 ×2. o_rd_data=0xDEAD with a 1-cycle o_rd_valid pulse. Ten back-to-back READs give ten pulses.
- Kernel beat gap: 10 idle cycles between beats -> o_gpio holds 0x7FA0, o_cmd_ready=1 and o_busy=0 throughout the gap.
- i_reset asserted during KHI (o_gpio=0x7FB0) -> o_gpio=0 and ready=0 within the same cycle. After release, RESET 0x1B7 runs normally.
